// File: rtl/square_wave_multi_pkg.sv
// Shared constants, width helpers and the saturating exponent step
// for the multi-channel square-wave generator.
package sqw_pkg;

  localparam int KEY_PLUS  = 0;
  localparam int KEY_MINUS = 1;
  localparam int KEY_SEL   = 2;

  typedef enum logic {
    KEY_UP   = 1'b0,
    KEY_DOWN = 1'b1
  } key_st_e;

  function automatic int sel_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  function automatic int exp_w(input int cnt_w);
    return (cnt_w <= 2) ? 1 : $clog2(cnt_w);
  endfunction

  // Up and down together cancel; a step past either end is dropped.
  function automatic int unsigned sat_step(input int unsigned e, input logic up,
                                           input logic dn, input int unsigned mx);
    sat_step = e;
    if (up && !dn && (e < mx)) sat_step = e + 1;
    else if (dn && !up && (e > 0)) sat_step = e - 1;
  endfunction

endpackage

// File: rtl/square_wave_multi_if.sv
// Key inputs and status/wave outputs of the square-wave generator.
interface sqw_if
  import sqw_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 24
);
  localparam int SEL_W = sel_w(CHANNELS);
  localparam int EXP_W = exp_w(CNT_W);

  logic                key_plus_i;
  logic                key_minus_i;
  logic                key_sel_i;
  logic [CHANNELS-1:0] wave_o;
  logic [SEL_W-1:0]    sel_o;
  logic [EXP_W-1:0]    exp_o;

  modport slave  (input  key_plus_i, key_minus_i, key_sel_i,
                  output wave_o, sel_o, exp_o);
  modport master (output key_plus_i, key_minus_i, key_sel_i,
                  input  wave_o, sel_o, exp_o);
endinterface

// File: rtl/square_wave_multi_key_conditioner.sv
// One raw key: 2-FF synchroniser, counting debouncer, press-edge pulse
// and optional hold-to-repeat timer.
module key_conditioner
  import sqw_pkg::*;
#(
  parameter int DEB_W      = 16,
  parameter int HOLD_CYC   = 2**22,
  parameter int REPEAT_CYC = 2**20,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_i,
  input  logic key_i,
  output logic state_o,
  output logic pulse_o
);
  localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYC - 1);

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] deb_q, deb_d;
  key_st_e          st_q, st_d;
  logic             pulse_q, pulse_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rep_q, rep_d;
  logic [TMR_W-1:0] lim;
  logic             flip, fire;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q  <= '0;
      deb_q   <= '0;
      st_q    <= KEY_UP;
      pulse_q <= 1'b0;
      tmr_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      deb_q   <= deb_d;
      st_q    <= st_d;
      pulse_q <= pulse_d;
      tmr_q   <= tmr_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    deb_d   = deb_q;
    st_d    = st_q;
    tmr_d   = tmr_q;
    rep_d   = rep_q;
    flip    = 1'b0;
    lim     = rep_q ? REP_LAST : HOLD_LAST;

    if (key_st_e'(sync_q[1]) == st_q) begin
      deb_d = '0;
    end else if (&deb_q) begin
      flip  = 1'b1;
      deb_d = '0;
      st_d  = (st_q == KEY_UP) ? KEY_DOWN : KEY_UP;
    end else begin
      deb_d = deb_q + DEB_W'(1);
    end

    // The press pulse is registered on the same edge the state rises, so it
    // lines up with the debounced state instead of trailing it by a cycle.
    fire = REPEAT_EN && (st_q == KEY_DOWN) && !flip && (tmr_q == lim);

    if (!REPEAT_EN || (st_q == KEY_UP) || flip) begin
      tmr_d = '0;
      rep_d = 1'b0;
    end else if (fire) begin
      tmr_d = '0;
      rep_d = 1'b1;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    pulse_d = (flip && (st_q == KEY_UP)) || fire;
  end

  assign state_o = (st_q == KEY_DOWN);
  assign pulse_o = pulse_q;

endmodule

// File: rtl/square_wave_multi.sv
// Multi-channel power-of-two square-wave generator: one shared counter,
// per-channel exponents programmed with plus/minus/select keys.
module square_wave_multi
  import sqw_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int CNT_W      = 24,
  parameter int RESET_EXP  = 0,
  parameter int DEB_W      = 16,
  parameter int HOLD_CYC   = 2**22,
  parameter int REPEAT_CYC = 2**20
) (
  input logic  clk,
  input logic  rst_i,
  sqw_if.slave bus
);
  localparam int SEL_W = sel_w(CHANNELS);
  localparam int EXP_W = exp_w(CNT_W);
  localparam logic [EXP_W-1:0] EXP_RST  = EXP_W'(RESET_EXP);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [2:0]          key_raw;
  logic [2:0]          key_pulse;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] wave_q, wave_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [EXP_W-1:0]    exp_q [CHANNELS];
  logic [EXP_W-1:0]    exp_d [CHANNELS];

  assign key_raw[KEY_PLUS]  = bus.key_plus_i;
  assign key_raw[KEY_MINUS] = bus.key_minus_i;
  assign key_raw[KEY_SEL]   = bus.key_sel_i;

  for (genvar k = 0; k < 3; k++) begin : gen_key
    key_conditioner #(
      .DEB_W     (DEB_W),
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .REPEAT_EN (k != KEY_SEL)
    ) u_key (
      .clk    (clk),
      .rst_i  (rst_i),
      .key_i  (key_raw[k]),
      .state_o(),
      .pulse_o(key_pulse[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (key_pulse[KEY_SEL]) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    // The step lands on the channel selected before this edge, even when
    // select advances on the same edge.
    for (int k = 0; k < CHANNELS; k++) begin
      exp_d[k]  = exp_q[k];
      if (SEL_W'(k) == sel_q)
        exp_d[k] = EXP_W'(sat_step(32'(exp_q[k]), key_pulse[KEY_PLUS],
                                   key_pulse[KEY_MINUS], CNT_W - 1));
      wave_d[k] = cnt_q[exp_q[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q  <= '0;
      wave_q <= '0;
      sel_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) exp_q[k] <= EXP_RST;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
      sel_q  <= sel_d;
      for (int k = 0; k < CHANNELS; k++) exp_q[k] <= exp_d[k];
    end
  end

  assign bus.wave_o = wave_q;
  assign bus.sel_o  = sel_q;
  assign bus.exp_o  = exp_q[sel_q];

endmodule

// File: tb/tb_square_wave_multi.sv
// Directed bench for square_wave_multi: key-sequence table plus timing,
// repeat, bounce and reset-during-hold sequences.
module tb_square_wave_multi;
  import sqw_pkg::*;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int DW = 2;
  localparam int HC = 16;
  localparam int RC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   tg [CH];

  sqw_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  square_wave_multi #(
    .CHANNELS  (CH),
    .CNT_W     (CW),
    .RESET_EXP (0),
    .DEB_W     (DW),
    .HOLD_CYC  (HC),
    .REPEAT_CYC(RC)
  ) dut (
    .clk  (clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic p;
    logic m;
    logic s;
    int   e_sel;
    int   e_exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic set_keys(input logic p, input logic m, input logic s);
    bus.key_plus_i  = p;
    bus.key_minus_i = m;
    bus.key_sel_i   = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic p, input logic m, input logic s, input int n);
    @(negedge clk);
    set_keys(p, m, s);
    idle(n);
    set_keys(1'b0, 1'b0, 1'b0);
    idle(12);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic count_toggles();
    logic [CH-1:0] prev;
    for (int k = 0; k < CH; k++) tg[k] = 0;
    prev = bus.wave_o;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) if (bus.wave_o[k] != prev[k]) tg[k]++;
      prev = bus.wave_o;
    end
  endtask

  vec_t vecs [12];
  int   exp_edges [7];
  int   chg [$];
  int   prev_exp;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 2, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 0, 1};
    exp_edges = '{7, 23, 31, 39, 47, 55, 63};

    set_keys(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(3);
    chk("reset wave_o", int'(bus.wave_o), 0);
    chk("reset sel_o", int'(bus.sel_o), 0);
    chk("reset exp_o", int'(bus.exp_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first wave after reset", int'(bus.wave_o), 0);
    @(negedge clk);
    chk("second wave after reset", int'(bus.wave_o), 7);
    count_toggles();
    for (int k = 0; k < CH; k++) chk($sformatf("exp0 toggles ch%0d", k), tg[k], 16);

    // Press-to-update latency: exp_o moves on the 7th edge after the press.
    @(negedge clk);
    bus.key_plus_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) chk("exp_o before edge 7", int'(bus.exp_o), 0);
      if (i == 7) chk("exp_o at edge 7", int'(bus.exp_o), 1);
    end
    bus.key_plus_i = 1'b0;
    idle(12);
    chk("exp_o after release", int'(bus.exp_o), 1);
    count_toggles();
    chk("exp1 toggles ch0", tg[0], 8);
    chk("exp0 toggles ch1", tg[1], 16);
    chk("exp0 toggles ch2", tg[2], 16);

    do_reset();
    for (int v = 0; v < 12; v++) begin
      press(vecs[v].p, vecs[v].m, vecs[v].s, 10);
      chk($sformatf("vec%0d sel_o", v), int'(bus.sel_o), vecs[v].e_sel);
      chk($sformatf("vec%0d exp_o", v), int'(bus.exp_o), vecs[v].e_exp);
    end

    // Bouncing plus: level never stable long enough to be accepted.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.key_plus_i = 1'b1;
      @(negedge clk);
      @(negedge clk); bus.key_plus_i = 1'b0;
      @(negedge clk);
    end
    idle(12);
    chk("bounce exp_o", int'(bus.exp_o), 1);
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0, 10);
    chk("plus saturation exp_o", int'(bus.exp_o), 7);

    // Held plus: press pulse then repeats at +16, then every 8.
    do_reset();
    @(negedge clk);
    bus.key_plus_i = 1'b1;
    prev_exp = int'(bus.exp_o);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (int'(bus.exp_o) != prev_exp) chg.push_back(i);
      prev_exp = int'(bus.exp_o);
      if (i == 60) bus.key_plus_i = 1'b0;
    end
    chk("repeat change count", chg.size(), 7);
    for (int j = 0; j < 7; j++)
      chk($sformatf("repeat edge %0d", j), (j < chg.size()) ? chg[j] : -1, exp_edges[j]);
    chk("repeat final exp_o", int'(bus.exp_o), 7);

    press(1'b1, 1'b1, 1'b0, 10);
    chk("plus+minus short exp_o", int'(bus.exp_o), 7);
    press(1'b1, 1'b1, 1'b0, 30);
    chk("plus+minus held exp_o", int'(bus.exp_o), 7);

    // Reset while plus is held: key is re-debounced from scratch.
    press(1'b0, 1'b0, 1'b1, 10);
    @(negedge clk);
    bus.key_plus_i = 1'b1;
    idle(20);
    chk("pre-reset exp_o", int'(bus.exp_o), 1);
    rst = 1'b1;
    idle(2);
    chk("mid-hold reset sel_o", int'(bus.sel_o), 0);
    chk("mid-hold reset exp_o", int'(bus.exp_o), 0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 6) chk("post-reset exp_o edge 6", int'(bus.exp_o), 0);
      if (i == 7) chk("post-reset exp_o edge 7", int'(bus.exp_o), 1);
    end
    bus.key_plus_i = 1'b0;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
